// File: rtl/cgra_kernel_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cgra_kernel_fetch_pkg
//  Description : Shared constants and types for the kernel-configuration word
//                (column mask / start line / instruction count) and the
//                kernel-fetch state machine.
//  Revision    : 1.0 - initial release
// ============================================================================
package cgra_kernel_fetch_pkg;

  // Field positions inside a kernel-memory word
  localparam int N_INSTR_LB  = 0;
  localparam int N_INSTR_HB  = 4;
  localparam int IMEM_ADD_LB = 5;
  localparam int IMEM_ADD_HB = 11;
  localparam int N_COL_LB    = 12;
  localparam int N_COL_HB    = 15;

  localparam int KMEM_WIDTH  = N_COL_HB + 1;

  localparam int N_INSTR_BITS  = N_INSTR_HB - N_INSTR_LB + 1;
  localparam int IMEM_ADD_BITS = IMEM_ADD_HB - IMEM_ADD_LB + 1;
  localparam int N_COL_BITS    = N_COL_HB - N_COL_LB + 1;

  // Kernel-fetch controller states
  typedef enum logic [2:0] {
    KF_IDLE     = 3'd0,
    KF_KREAD    = 3'd1,
    KF_DECODE   = 3'd2,
    KF_WAIT_COL = 3'd3,
    KF_FETCH    = 3'd4
  } cgra_kfetch_state_t;

  // Unpacked view of a kernel-memory word (MSB first, matching the layout)
  typedef struct packed {
    logic [N_COL_BITS-1:0]    cols;
    logic [IMEM_ADD_BITS-1:0] start;
    logic [N_INSTR_BITS-1:0]  n_instr;
  } kmem_word_t;

endpackage : cgra_kernel_fetch_pkg
`default_nettype wire

// File: rtl/cgra_kernel_fetch_kmem_decode.sv
`default_nettype none
// ============================================================================
//  Module      : cgra_kmem_decode
//  Description : Combinational unpack of a kernel-memory word plus the launch
//                validity check (empty column mask, instruction range running
//                past the last instruction-memory line).
//  Revision    : 1.0 - initial release
// ============================================================================
module cgra_kmem_decode
  import cgra_kernel_fetch_pkg::*;
(
  input  logic [KMEM_WIDTH-1:0]    word,
  output logic [N_COL_BITS-1:0]    cols,
  output logic [IMEM_ADD_BITS-1:0] start,
  output logic [N_INSTR_BITS-1:0]  n_instr,
  output logic                     bad
);

  kmem_word_t                 fields;
  logic [IMEM_ADD_BITS:0]     last_line;
  logic [IMEM_ADD_BITS:0]     line_limit;

  assign fields  = kmem_word_t'(word);
  assign cols    = fields.cols;
  assign start   = fields.start;
  assign n_instr = fields.n_instr;

  // Last line touched, one bit wider than the address so it cannot wrap
  assign last_line  = {1'b0, fields.start}
                    + {{(IMEM_ADD_BITS+1-N_INSTR_BITS){1'b0}}, fields.n_instr};
  assign line_limit = {1'b0, {IMEM_ADD_BITS{1'b1}}};

  // Reject kernels that claim no columns or overrun instruction memory
  always_comb begin
    bad = 1'b0;
    if (fields.cols == '0)
      bad = 1'b1;
    if (last_line > line_limit)
      bad = 1'b1;
  end

endmodule : cgra_kmem_decode
`default_nettype wire

// File: rtl/cgra_kernel_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : cgra_kernel_fetch
//  Description : Launch-side kernel fetcher. Reads one kernel-memory entry,
//                decodes it, waits for the requested columns to be free, claims
//                them and streams the kernel's instruction-memory line
//                addresses, one per granted cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module cgra_kernel_fetch
  import cgra_kernel_fetch_pkg::*;
#(
  parameter int N_COL      = N_COL_BITS,
  parameter int KER_ID_W   = 4,
  parameter int IMEM_ADD_W = IMEM_ADD_BITS,
  parameter int NINSTR_W   = N_INSTR_BITS,
  parameter int KMEM_W     = KMEM_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [KER_ID_W-1:0]   ker_id_i,
  input  logic [N_COL-1:0]      col_free_i,
  output logic                  kmem_req_o,
  output logic [KER_ID_W-1:0]   kmem_addr_o,
  input  logic [KMEM_W-1:0]     kmem_rdata_i,
  output logic [N_COL-1:0]      col_acq_o,
  output logic                  imem_req_o,
  output logic [IMEM_ADD_W-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  cgra_kfetch_state_t     state_q, state_d;

  logic [KER_ID_W-1:0]    id_q;
  logic [N_COL-1:0]       col_q;
  logic [IMEM_ADD_W-1:0]  addr_q;
  logic [NINSTR_W-1:0]    cnt_q;
  logic                   done_q;
  logic                   err_q;

  logic [N_COL-1:0]       dec_cols;
  logic [IMEM_ADD_W-1:0]  dec_start;
  logic [NINSTR_W-1:0]    dec_n_instr;
  logic                   dec_bad;

  logic                   launch;
  logic                   null_launch;
  logic                   decode_bad;
  logic                   cols_ready;
  logic                   grant;
  logic                   last_grant;

  cgra_kmem_decode u_decode (
    .word    (kmem_rdata_i),
    .cols    (dec_cols),
    .start   (dec_start),
    .n_instr (dec_n_instr),
    .bad     (dec_bad)
  );

  assign launch      = (state_q == KF_IDLE) && start_i;
  assign null_launch = launch && (ker_id_i == '0);
  assign decode_bad  = (state_q == KF_DECODE) && dec_bad;
  assign cols_ready  = ((col_free_i & col_q) == col_q);
  assign grant       = (state_q == KF_FETCH) && imem_gnt_i;
  assign last_grant  = grant && (cnt_q == '0);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      state_q <= KF_IDLE;
    else
      state_q <= state_d;
  end

  // Next-state and per-state outputs
  always_comb begin
    state_d     = state_q;
    kmem_req_o  = 1'b0;
    kmem_addr_o = '0;
    col_acq_o   = '0;
    imem_req_o  = 1'b0;
    imem_addr_o = '0;
    busy_o      = 1'b1;
    case (state_q)
      KF_IDLE: begin
        busy_o = 1'b0;
        if (launch && !null_launch)
          state_d = KF_KREAD;
      end
      KF_KREAD: begin
        kmem_req_o  = 1'b1;
        kmem_addr_o = id_q;
        state_d     = KF_DECODE;
      end
      KF_DECODE: begin
        state_d = dec_bad ? KF_IDLE : KF_WAIT_COL;
      end
      KF_WAIT_COL: begin
        if (cols_ready) begin
          col_acq_o = col_q;
          state_d   = KF_FETCH;
        end
      end
      KF_FETCH: begin
        imem_req_o  = 1'b1;
        imem_addr_o = addr_q;
        if (last_grant)
          state_d = KF_IDLE;
      end
      default: begin
        state_d = KF_IDLE;
      end
    endcase
  end

  // Launch id, decoded fields and the fetch address/count
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      id_q   <= '0;
      col_q  <= '0;
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (launch)
        id_q <= ker_id_i;
      // Start line and count are captured at decode so WAIT_COL only has to
      // compare columns; the fetch starts from exactly these values.
      if (state_q == KF_DECODE) begin
        col_q  <= dec_cols;
        addr_q <= dec_start;
        cnt_q  <= dec_n_instr;
      end
      if (grant) begin
        addr_q <= addr_q + 1'b1;
        cnt_q  <= cnt_q - 1'b1;
      end
    end
  end

  // Completion and rejection pulses, one cycle after their cause
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= last_grant;
      err_q  <= null_launch || decode_bad;
    end
  end

  assign done_o = done_q;
  assign err_o  = err_q;

endmodule : cgra_kernel_fetch
`default_nettype wire

// File: tb/tb_cgra_kernel_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cgra_kernel_fetch
//  Description : Directed self-checking bench for cgra_kernel_fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cgra_kernel_fetch;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  ker_id;
  logic [3:0]  col_free;
  logic        kmem_req;
  logic [3:0]  kmem_addr;
  logic [15:0] kmem_rdata;
  logic [3:0]  col_acq;
  logic        imem_req;
  logic [6:0]  imem_addr;
  logic        imem_gnt;
  logic        busy;
  logic        done;
  logic        err;

  logic [15:0] kmem [16];

  int checks = 0;
  int errors = 0;
  int acq_count;

  cgra_kernel_fetch dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .ker_id_i     (ker_id),
    .col_free_i   (col_free),
    .kmem_req_o   (kmem_req),
    .kmem_addr_o  (kmem_addr),
    .kmem_rdata_i (kmem_rdata),
    .col_acq_o    (col_acq),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_gnt_i   (imem_gnt),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Kernel memory: data returned one cycle after the read strobe
  always @(posedge clk) begin
    if (kmem_req)
      kmem_rdata <= kmem[kmem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) kmem[i] = 16'h0000;
    kmem[3]  = 16'h1143; // cols 0001 start 10  n 3
    kmem[5]  = 16'h1FC3; // cols 0001 start 126 n 3 -> overrun
    kmem[6]  = 16'h0143; // cols 0000 -> reject
    kmem[7]  = 16'hC280; // cols 1100 start 20  n 0
    kmem[8]  = 16'h2501; // cols 0010 start 40  n 1
    kmem[9]  = 16'h1642; // cols 0001 start 50  n 2
    kmem[10] = 16'h1F83; // cols 0001 start 124 n 3 -> ends at 127 exactly
    kmem_rdata = 16'h0000;
    rst = 1'b1; start = 1'b0; ker_id = 4'd0; col_free = 4'hF; imem_gnt = 1'b1;
    tick(); tick();

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_kmem_req", kmem_req, 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_col_acq", col_acq, 0);
    rst = 1'b0;
    tick();

    // Normal launch of kernel 3
    start = 1'b1; ker_id = 4'd3;
    tick(); start = 1'b0;
    chk("n_busy", busy, 1);
    chk("n_kmem_req", kmem_req, 1);
    chk("n_kmem_addr", kmem_addr, 3);
    tick();
    chk("n_kmem_req_once", kmem_req, 0);
    tick();
    chk("n_col_acq", col_acq, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("n_imem_req", imem_req, 1);
      chk("n_imem_addr", imem_addr, 10 + i);
      chk("n_no_done", done, 0);
    end
    tick();
    chk("n_done", done, 1);
    chk("n_idle", busy, 0);
    chk("n_imem_req_off", imem_req, 0);
    tick();
    chk("n_done_pulse", done, 0);

    // Null kernel
    start = 1'b1; ker_id = 4'd0;
    #1;
    chk("z_no_kmem_req", kmem_req, 0);
    tick(); start = 1'b0;
    chk("z_err", err, 1);
    chk("z_idle", busy, 0);
    chk("z_no_kmem_req2", kmem_req, 0);
    tick();
    chk("z_err_pulse", err, 0);

    // Range overrun (126 + 3)
    start = 1'b1; ker_id = 4'd5;
    tick(); start = 1'b0;
    tick(); tick();
    chk("r_err", err, 1);
    chk("r_no_imem_req", imem_req, 0);
    chk("r_idle", busy, 0);
    chk("r_no_acq", col_acq, 0);
    tick();

    // Empty column mask
    start = 1'b1; ker_id = 4'd6;
    tick(); start = 1'b0;
    tick(); tick();
    chk("c_err", err, 1);
    chk("c_idle", busy, 0);
    tick();

    // Boundary: 124 + 3 = 127 is accepted
    start = 1'b1; ker_id = 4'd10;
    tick(); start = 1'b0;
    tick(); tick();
    chk("b_no_err", err, 0);
    chk("b_col_acq", col_acq, 4'b0001);
    tick(); tick(); tick(); tick();
    chk("b_last_addr", imem_addr, 127);
    tick();
    chk("b_done", done, 1);
    tick();

    // Column wait: need 1100, only 0100 free for a while
    col_free = 4'b0100; acq_count = 0;
    start = 1'b1; ker_id = 4'd7;
    tick(); start = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      if (col_acq != 4'b0000) acq_count++;
      chk("w_busy", busy, 1);
      chk("w_no_imem_req", imem_req, 0);
    end
    col_free = 4'b1111;
    #1;
    chk("w_col_acq", col_acq, 4'b1100);
    if (col_acq != 4'b0000) acq_count++;
    tick();
    if (col_acq != 4'b0000) acq_count++;
    chk("w_imem_addr", imem_addr, 20);
    chk("w_acq_once", acq_count, 1);
    tick();
    chk("w_done", done, 1);
    tick();

    // Grant backpressure, two words at 40/41
    imem_gnt = 1'b0;
    start = 1'b1; ker_id = 4'd8;
    tick(); start = 1'b0;
    tick(); tick();
    chk("g_col_acq", col_acq, 4'b0010);
    tick();
    chk("g_addr0", imem_addr, 40);
    tick();
    chk("g_addr0_held", imem_addr, 40);
    chk("g_req_held", imem_req, 1);
    imem_gnt = 1'b1;
    tick(); imem_gnt = 1'b0;
    chk("g_addr1", imem_addr, 41);
    chk("g_no_done", done, 0);
    tick();
    chk("g_addr1_held", imem_addr, 41);
    chk("g_no_done2", done, 0);
    imem_gnt = 1'b1;
    tick();
    chk("g_done", done, 1);
    chk("g_idle", busy, 0);
    tick();

    // Start while busy is ignored; reset mid-fetch aborts
    start = 1'b1; ker_id = 4'd9;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    chk("x_addr0", imem_addr, 50);
    start = 1'b1; ker_id = 4'd3;
    tick(); start = 1'b0;
    chk("x_addr1", imem_addr, 51);
    chk("x_no_kmem_req", kmem_req, 0);
    rst = 1'b1;
    #1;
    chk("x_rst_imem_req", imem_req, 0);
    chk("x_rst_imem_addr", imem_addr, 0);
    chk("x_rst_busy", busy, 0);
    tick();
    chk("x_rst_done", done, 0);
    chk("x_rst_err", err, 0);
    rst = 1'b0;
    tick();
    chk("x_post_done", done, 0);
    chk("x_post_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_cgra_kernel_fetch
`default_nettype wire
